// File: rtl/led_anim_pkg.sv
// led_anim_pkg: shared mode encoding, FSM states and mode step helpers
// used by mode_selector and its button front end.
package led_anim_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_RUN  = 2'd0;
   localparam mode_t MODE_FILL = 2'd1;
   localparam mode_t MODE_PWM  = 2'd2;
   localparam mode_t MODE_OFF  = 2'd3;

   localparam int NUM_MODES_DEF = 4;

   typedef enum logic {
      IDLE,
      HELD
   } state_t;

   function automatic mode_t mode_inc(
      input mode_t m,
      input int    n
   );
      return (int'(m) == n - 1) ? MODE_RUN
                                : mode_t'(m + 2'd1);
   endfunction

   function automatic mode_t mode_dec(
      input mode_t m,
      input int    n
   );
      return (m == MODE_RUN) ? mode_t'(n - 1)
                             : mode_t'(m - 2'd1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-count debouncer and
// rising-edge press pulse for one raw push-button.
module btn_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CW = (DB_CYCLES > 1) ?
                       $clog2(DB_CYCLES) : 1;

   logic          s1;
   logic          s2;
   logic          level_q;
   logic [CW-1:0] cnt;

   // sync chain, debounce counter and delayed level for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         s1      <= btn;
         s2      <= s1;
         level_q <= level;
         if (s2 != level) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
               level <= s2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/mode_selector.sv
// mode_selector: button-driven wrapping mode counter with hold-repeat.
// Build with MODE_SELECTOR_AUTO_CYCLE_EN for idle auto-advance.
import led_anim_pkg::*;

module mode_selector #(
   parameter int DB_CYCLES   = 4,
   parameter int REPEAT_CYC  = 0,
   parameter int AUTO_PERIOD = 64,
   parameter int NUM_MODES   = NUM_MODES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_prev,
   output logic [1:0] mode,
   output logic       mode_chg
);

   localparam int RW = (REPEAT_CYC > 1) ?
                       $clog2(REPEAT_CYC) : 1;

   logic          lvl_n;
   logic          prs_n;
   logic          lvl_p;
   logic          prs_p;

   state_t        state;
   state_t        state_d;
   mode_t         mode_q;
   mode_t         mode_d;
   logic          chg_q;
   logic          chg_d;
   logic [RW-1:0] rep_cnt;
   logic [RW-1:0] rep_cnt_d;
   logic [1:0]    rep_dir;
   logic [1:0]    rep_dir_d;
   logic          rep_ok;
   logic          both_lo;

`ifdef MODE_SELECTOR_AUTO_CYCLE_EN
   localparam int AW = (AUTO_PERIOD > 1) ?
                       $clog2(AUTO_PERIOD) : 1;

   logic [AW-1:0] idle_cnt;
   logic [AW-1:0] idle_cnt_d;
`else
   localparam int unused_auto = AUTO_PERIOD;
`endif

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_next (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_next),
      .level (lvl_n),
      .press (prs_n)
   );

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_prev (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_prev),
      .level (lvl_p),
      .press (prs_p)
   );

   assign both_lo = ~lvl_n & ~lvl_p;

   // repeat only for the latched button while it alone is down
   assign rep_ok = (rep_dir[1] & lvl_n & ~lvl_p) |
                   (rep_dir[0] & lvl_p & ~lvl_n);

   // next-state, mode step and counter updates
   always_comb begin
      state_d   = state;
      mode_d    = mode_q;
      chg_d     = 1'b0;
      rep_cnt_d = '0;
      rep_dir_d = rep_dir;
`ifdef MODE_SELECTOR_AUTO_CYCLE_EN
      idle_cnt_d = '0;
`endif
      unique case (state)
         IDLE: begin
            if (prs_n | prs_p) begin
               state_d   = HELD;
               rep_dir_d = {prs_n & ~prs_p,
                            prs_p & ~prs_n};
               unique case (1'b1)
                  prs_n & ~prs_p: begin
                     mode_d = mode_inc(mode_q, NUM_MODES);
                     chg_d  = 1'b1;
                  end
                  prs_p & ~prs_n: begin
                     mode_d = mode_dec(mode_q, NUM_MODES);
                     chg_d  = 1'b1;
                  end
                  default: ;
               endcase
            end
`ifdef MODE_SELECTOR_AUTO_CYCLE_EN
            else if (both_lo) begin
               if (idle_cnt == AW'(AUTO_PERIOD - 1)) begin
                  mode_d = mode_inc(mode_q, NUM_MODES);
                  chg_d  = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt + AW'(1);
               end
            end
`endif
         end
         HELD: begin
            if (both_lo) begin
               state_d   = IDLE;
               rep_dir_d = '0;
            end else if ((rep_dir[1] & prs_p) |
                         (rep_dir[0] & prs_n)) begin
               rep_dir_d = '0;
            end else if (REPEAT_CYC != 0 && rep_ok) begin
               if (rep_cnt == RW'(REPEAT_CYC - 1)) begin
                  chg_d = 1'b1;
                  unique case (1'b1)
                     rep_dir[1]:
                        mode_d = mode_inc(mode_q, NUM_MODES);
                     rep_dir[0]:
                        mode_d = mode_dec(mode_q, NUM_MODES);
                     default: ;
                  endcase
               end else begin
                  rep_cnt_d = rep_cnt + RW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, mode and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mode_q  <= MODE_RUN;
         chg_q   <= 1'b0;
         rep_cnt <= '0;
         rep_dir <= '0;
`ifdef MODE_SELECTOR_AUTO_CYCLE_EN
         idle_cnt <= '0;
`endif
      end else begin
         state   <= state_d;
         mode_q  <= mode_d;
         chg_q   <= chg_d;
         rep_cnt <= rep_cnt_d;
         rep_dir <= rep_dir_d;
`ifdef MODE_SELECTOR_AUTO_CYCLE_EN
         idle_cnt <= idle_cnt_d;
`endif
      end
   end

   assign mode     = mode_q;
   assign mode_chg = chg_q;

endmodule

// File: tb/tb_mode_selector.sv
// tb_mode_selector: directed scoreboard bench for mode_selector.
// Auto-advance checks follow MODE_SELECTOR_AUTO_CYCLE_EN.
import led_anim_pkg::*;

module tb_mode_selector;

   logic  clk = 1'b0;
   logic  rst;
   logic  rst_a;
   logic  bn, bp, rn, rp, an, ap;
   mode_t m_m, m_r, m_a;
   logic  c_m, c_r, c_a;

   mode_t q_m[$];
   mode_t q_r[$];
   mode_t q_a[$];

   int vectors;
   int miscompares;
   int n_m, n_r, n_a;
   int at, t1, t2;
   mode_t em;

   always #5 clk = ~clk;

   mode_selector #(
      .DB_CYCLES   (4),
      .REPEAT_CYC  (0),
      .AUTO_PERIOD (100000),
      .NUM_MODES   (4)
   ) u_main (
      .clk      (clk),
      .rst      (rst),
      .btn_next (bn),
      .btn_prev (bp),
      .mode     (m_m),
      .mode_chg (c_m)
   );

   mode_selector #(
      .DB_CYCLES   (4),
      .REPEAT_CYC  (8),
      .AUTO_PERIOD (100000),
      .NUM_MODES   (4)
   ) u_rep (
      .clk      (clk),
      .rst      (rst),
      .btn_next (rn),
      .btn_prev (rp),
      .mode     (m_r),
      .mode_chg (c_r)
   );

   mode_selector #(
      .DB_CYCLES   (4),
      .REPEAT_CYC  (0),
      .AUTO_PERIOD (16),
      .NUM_MODES   (4)
   ) u_auto (
      .clk      (clk),
      .rst      (rst_a),
      .btn_next (an),
      .btn_prev (ap),
      .mode     (m_a),
      .mode_chg (c_a)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (c_m) begin
         n_m++;
         if (q_m.size() == 0) chk("main_unexp_chg", 1, 0);
         else chk("main_mode", m_m, q_m.pop_front());
      end
      if (c_r) begin
         n_r++;
         if (q_r.size() == 0) chk("rep_unexp_chg", 1, 0);
         else chk("rep_mode", m_r, q_r.pop_front());
      end
      if (c_a) begin
         n_a++;
         if (q_a.size() == 0) chk("auto_unexp_chg", 1, 0);
         else chk("auto_mode", m_a, q_a.pop_front());
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   function automatic int cnt_of(input int w);
      case (w)
         0:       return n_m;
         1:       return n_r;
         default: return n_a;
      endcase
   endfunction

   task automatic wait_chg(
      input  int w,
      input  int lim,
      output int t
   );
      int n0;
      n0 = cnt_of(w);
      t  = -1;
      for (int i = 1; i <= lim; i++) begin
         cyc();
         if (t < 0 && cnt_of(w) != n0) t = i;
      end
   endtask

   task automatic press_m(input logic nx, input logic pv);
      bn = nx;
      bp = pv;
      cycles(10);
      bn = 1'b0;
      bp = 1'b0;
      cycles(20);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      n_m = 0; n_r = 0; n_a = 0;
      rst = 1'b1; rst_a = 1'b1;
      bn = 0; bp = 0; rn = 0; rp = 0; an = 0; ap = 0;

      cycles(3);
      chk("rst_mode_main", m_m, MODE_RUN);
      chk("rst_chg_main",  c_m, 0);
      chk("rst_mode_rep",  m_r, MODE_RUN);
      chk("rst_chg_rep",   c_r, 0);
      chk("rst_mode_auto", m_a, MODE_RUN);
      rst = 1'b0;
      cycles(5);

      // single clean press: exact latency, one step
      bn = 1'b1;
      q_m.push_back(MODE_FILL);
      wait_chg(0, 9, at);
      chk("t1_latency", at, 7);
      cyc();
      bn = 1'b0;
      cycles(20);
      chk("t1_steps", n_m, 1);
      chk("t1_mode", m_m, MODE_FILL);

      // 3-cycle glitch is ignored
      bn = 1'b1;
      cycles(3);
      bn = 1'b0;
      cycles(15);
      chk("t2_glitch_steps", n_m, 1);
      chk("t2_glitch_mode", m_m, MODE_FILL);

      // next wraps 3->0, prev wraps 0->3
      em = MODE_FILL;
      for (int i = 0; i < 4; i++) begin
         em = (em == MODE_OFF) ? MODE_RUN : em + 2'd1;
         q_m.push_back(em);
         press_m(1'b1, 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
         em = (em == MODE_RUN) ? MODE_OFF : em - 2'd1;
         q_m.push_back(em);
         press_m(1'b0, 1'b1);
      end
      chk("t3_steps", n_m, 7);
      chk("t3_mode", m_m, MODE_OFF);

      // simultaneous press: no change; then next works
      press_m(1'b1, 1'b1);
      chk("t4_both_steps", n_m, 7);
      chk("t4_both_mode", m_m, MODE_OFF);
      q_m.push_back(MODE_RUN);
      press_m(1'b1, 1'b0);
      chk("t4_next_mode", m_m, MODE_RUN);

      // hold-repeat every 8 cycles, 4 steps, wraps
      rn = 1'b1;
      q_r.push_back(MODE_FILL);
      q_r.push_back(MODE_PWM);
      q_r.push_back(MODE_OFF);
      q_r.push_back(MODE_RUN);
      cycles(30);
      rn = 1'b0;
      cycles(25);
      chk("t5_rep_steps", n_r, 4);
      chk("t5_rep_mode", m_r, MODE_RUN);

      // other button during hold locks repeat
      rn = 1'b1;
      q_r.push_back(MODE_FILL);
      cycles(5);
      rp = 1'b1;
      cycles(15);
      rp = 1'b0;
      cycles(25);
      rn = 1'b0;
      cycles(20);
      chk("t5_lock_steps", n_r, 5);
      chk("t5_lock_mode", m_r, MODE_FILL);

      // async reset mid-hold
      rn = 1'b1;
      q_r.push_back(MODE_PWM);
      q_r.push_back(MODE_OFF);
      cycles(20);
      #3;
      rst = 1'b1;
      #1;
      chk("t5_rst_mode", m_r, MODE_RUN);
      chk("t5_rst_chg", c_r, 0);
      chk("t5_rst_main", m_m, MODE_RUN);
      cyc();

      // button held through reset release
      rst = 1'b0;
      q_r.push_back(MODE_FILL);
      wait_chg(1, 8, at);
      chk("t5_held_latency", at, 7);
      rn = 1'b0;
      cycles(20);
      chk("t5_held_mode", m_r, MODE_FILL);

`ifdef MODE_SELECTOR_AUTO_CYCLE_EN
      // auto advance every 16 idle cycles with wrap
      rst_a = 1'b0;
      em = MODE_RUN;
      for (int i = 0; i < 4; i++) begin
         em = (em == MODE_OFF) ? MODE_RUN : em + 2'd1;
         q_a.push_back(em);
         wait_chg(2, 20, at);
         chk("t6_auto_period", at, 16);
      end
      chk("t6_auto_wrap", m_a, MODE_RUN);
      // a press restarts the interval
      an = 1'b1;
      q_a.push_back(MODE_FILL);
      q_a.push_back(MODE_PWM);
      t1 = -1;
      t2 = -1;
      for (int i = 1; i <= 40; i++) begin
         at = n_a;
         cyc();
         if (i == 5) an = 1'b0;
         if (n_a != at && t1 < 0) t1 = i;
         else if (n_a != at && t2 < 0) t2 = i;
      end
      chk("t6_press_at", t1, 7);
      chk("t6_auto_after", t2, 28);
      chk("t6_auto_mode", m_a, MODE_PWM);
`else
      // no auto advance without the feature
      rst_a = 1'b0;
      cycles(200);
      chk("t6_no_auto_steps", n_a, 0);
      chk("t6_no_auto_mode", m_a, MODE_RUN);
`endif

      chk("q_main_empty", q_m.size(), 0);
      chk("q_rep_empty",  q_r.size(), 0);
      chk("q_auto_empty", q_a.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
